// File: rtl/trig_prm_scheduler_pkg.sv
// trig_prm_scheduler_pkg: shared state encoding, parameter-word layout and default sizes
package trig_prm_scheduler_pkg;
  localparam int DEF_DEPTH   = 8;
  localparam int DEF_DWELL_W = 16;
  localparam int MODE_BIT    = 24;
  localparam int ACTIVE_BIT  = MODE_BIT + 1;
  localparam int COUNT_MSB   = MODE_BIT - 1;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DWELL, S_NEXT, S_DONE} state_t;
  typedef struct packed {
    logic [31:ACTIVE_BIT+1] rsv;
    logic                   active;
    logic                   mode;
    logic [COUNT_MSB:0]     count;
  } prm_t;
endpackage

// File: rtl/trig_prm_scheduler_table.sv
// trig_prm_table: DEPTH-entry store of {parameter word, dwell}, one write port, one combinational read port
// Ports: i_clk; i_we/i_waddr/i_wprm/i_wdwell write; i_raddr -> o_rprm/o_rdwell read.
// Contents are deliberately not reset.
module trig_prm_table
  import trig_prm_scheduler_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int AW      = 3,
  parameter int DWELL_W = DEF_DWELL_W
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [AW-1:0]      i_waddr,
  input  prm_t               i_wprm,
  input  logic [DWELL_W-1:0] i_wdwell,
  input  logic [AW-1:0]      i_raddr,
  output prm_t               o_rprm,
  output logic [DWELL_W-1:0] o_rdwell
);
  prm_t               r_prm   [DEPTH];
  logic [DWELL_W-1:0] r_dwell [DEPTH];
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_prm[i_waddr]   <= i_wprm;
      r_dwell[i_waddr] <= i_wdwell;
    end
  end
  assign o_rprm   = r_prm[i_raddr];
  assign o_rdwell = r_dwell[i_raddr];
endmodule

// File: rtl/trig_prm_scheduler.sv
// trig_prm_scheduler: playlist controller that loads trigger parameter words at frame boundaries
// Ports: i_clk, i_rst (async, active-high); i_start/i_stop run control; i_loop, i_last_idx sampled at start;
//   i_tbl_* table write; i_head_flag frame marker; o_ena/o_prm_we/o_prmeter drive the trigger generator;
//   o_busy, o_done, o_idx, o_tbl_err status. Optional macro TRIG_SCHED_WATCHDOG_EN adds o_timeout.
module trig_prm_scheduler
  import trig_prm_scheduler_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int AW      = 3,
  parameter int DWELL_W = DEF_DWELL_W
`ifdef TRIG_SCHED_WATCHDOG_EN
  , parameter logic [23:0] TIMEOUT_CYCLES = 24'd10230000
`endif
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_loop,
  input  logic [AW-1:0]      i_last_idx,
  input  logic               i_tbl_we,
  input  logic [AW-1:0]      i_tbl_addr,
  input  logic [31:0]        i_tbl_prm,
  input  logic [DWELL_W-1:0] i_tbl_dwell,
  input  logic               i_head_flag,
  output logic               o_ena,
  output logic               o_prm_we,
  output logic [31:0]        o_prmeter,
  output logic               o_busy,
  output logic               o_done,
  output logic [AW-1:0]      o_idx,
  output logic               o_tbl_err
`ifdef TRIG_SCHED_WATCHDOG_EN
  , output logic             o_timeout
`endif
);
  state_t             r_state, w_nxt;
  logic               r_head_d, r_loop, r_ena, r_prm_we, r_busy, r_done, r_tbl_err;
  logic [AW-1:0]      r_last, r_idx, w_idx_nxt;
  logic [DWELL_W-1:0] r_cnt, r_dwell, w_dwell_eff, w_rd_dwell;
  logic [DWELL_W:0]   w_cnt_inc;
  prm_t               r_prm, w_rd_prm;
  logic               w_head_edge, w_dwell_hit, w_wd_hit, w_start;

  // The read port is addressed by the index about to be loaded so the word can be registered in LOAD.
  trig_prm_table #(.DEPTH(DEPTH), .AW(AW), .DWELL_W(DWELL_W)) u_tbl (
    .i_clk    (i_clk),
    .i_we     (i_tbl_we & ~r_busy),
    .i_waddr  (i_tbl_addr),
    .i_wprm   (prm_t'(i_tbl_prm)),
    .i_wdwell (i_tbl_dwell),
    .i_raddr  (w_idx_nxt),
    .o_rprm   (w_rd_prm),
    .o_rdwell (w_rd_dwell)
  );

  assign w_head_edge = i_head_flag & ~r_head_d;
  assign w_dwell_eff = (r_dwell == '0) ? DWELL_W'(1) : r_dwell;
  assign w_cnt_inc   = {1'b0, r_cnt} + 1'b1;
  assign w_dwell_hit = w_head_edge && (w_cnt_inc >= {1'b0, w_dwell_eff});

  always_comb begin
    w_nxt     = r_state;
    w_idx_nxt = r_idx;
    w_start   = 1'b0;
    if (i_stop) w_nxt = S_IDLE;
    else begin
      case (r_state)
        S_IDLE, S_DONE: if (i_start) begin
          w_nxt     = S_LOAD;
          w_idx_nxt = '0;
          w_start   = 1'b1;
        end
        S_LOAD:  w_nxt = S_DWELL;
        S_DWELL: if (w_dwell_hit || w_wd_hit) w_nxt = S_NEXT;
        S_NEXT: begin
          w_nxt     = (r_idx != r_last || r_loop) ? S_LOAD : S_DONE;
          w_idx_nxt = (r_idx != r_last) ? r_idx + 1'b1 : '0;
        end
        default: w_nxt = S_IDLE;
      endcase
    end
  end

  // Enable drops during the first LOAD of a run (including a restart from DONE) so the generator
  // sees a fresh rising enable with the new parameters one cycle after the write strobe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_head_d  <= 1'b0;
      r_loop    <= 1'b0;
      r_last    <= '0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_dwell   <= '0;
      r_prm     <= '0;
      r_ena     <= 1'b0;
      r_prm_we  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_tbl_err <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_head_d  <= i_head_flag;
      r_prm_we  <= (w_nxt == S_LOAD);
      r_busy    <= (w_nxt == S_LOAD) || (w_nxt == S_DWELL) || (w_nxt == S_NEXT);
      r_done    <= (r_state == S_NEXT) && (w_nxt == S_DONE);
      r_tbl_err <= i_tbl_we & r_busy;
      r_ena     <= (w_nxt == S_IDLE || w_start) ? 1'b0 : (w_nxt == S_DWELL) ? 1'b1 : r_ena;
      if (w_start) begin
        r_loop <= i_loop;
        r_last <= i_last_idx;
      end
      if (w_nxt == S_LOAD) begin
        r_idx   <= w_idx_nxt;
        r_prm   <= w_rd_prm;
        r_dwell <= w_rd_dwell;
        r_cnt   <= '0;
      end else if (r_state == S_DWELL && w_head_edge && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
  end

`ifdef TRIG_SCHED_WATCHDOG_EN
  logic [23:0] r_wd;
  logic        r_timeout;
  // Mode-0 entries never raise the head flag, so a stalled frame counter is forced onward.
  assign w_wd_hit  = (r_state == S_DWELL) && (r_wd == TIMEOUT_CYCLES - 24'd1);
  assign o_timeout = r_timeout;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_wd      <= (r_state == S_DWELL && w_nxt == S_DWELL && !w_head_edge) ? r_wd + 1'b1 : '0;
      r_timeout <= w_start ? 1'b0 : (r_timeout | (w_wd_hit && w_nxt == S_NEXT));
    end
  end
`else
  assign w_wd_hit = 1'b0;
`endif

  assign o_ena     = r_ena;
  assign o_prm_we  = r_prm_we;
  assign o_prmeter = r_prm;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_idx     = r_idx;
  assign o_tbl_err = r_tbl_err;
endmodule
